// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file access controller.
//   DW / AW / NREG : data width, address width, register count (NREG == 2**AW)
//   state_t        : controller FSM states
//   PORT_A/PORT_B  : requester ids, also the bit positions in the grant vector
package regfile_pkg;

   localparam int DW   = 8;
   localparam int AW   = 2;
   localparam int NREG = 4;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// One requester port of the register-file access controller.
//   req/we/addr/wdata : request from the requester, held stable until gnt
//   gnt               : combinational grant for this cycle
//   rvalid            : one-cycle pulse the cycle after a read grant
//   rdata             : read data, held until the next read grant of the port
// modport master = requester side, modport slave = controller side.
interface regfile_access_ctrl_if;
   import regfile_pkg::*;

   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
//   req_a, req_b : requests
//   en           : arbitration allowed this cycle
//   last_gnt     : port granted most recently (PORT_A / PORT_B)
//   gnt          : one-hot grant, bit PORT_A = port A, bit PORT_B = port B
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic       req_a,
   input  logic       req_b,
   input  logic       en,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      // NOTE: default every output first so no path leaves it unassigned (no latch).
      gnt = 2'b00;
      if (en) begin
         if (req_a && req_b) begin
            // Contention: the port that did not win last time goes first.
            if (last_gnt == PORT_A) gnt[PORT_B] = 1'b1;
            else                    gnt[PORT_A] = 1'b1;
         end else begin
            gnt[PORT_A] = req_a;
            gnt[PORT_B] = req_b;
         end
      end
   end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequencer and arbiter in front of a 4x8 single-port register file.
// After reset, and on clr_start, every register is cleared one per cycle
// (the register file's rst only clears the addressed entry). Otherwise the
// two requester ports share the file through a round-robin arbiter.
//   clk, rst         : clock, asynchronous active-low reset
//   clr_start        : one-cycle clear request (ignored while clearing)
//   clr_busy         : clear sequence running
//   a_if, b_if       : requester ports (slave side)
//   rf_addr/rf_data  : register file address / write data
//   rf_rst/rf_write  : register file clear / write strobes
//   rf_out           : register file read data
module regfile_access_ctrl
   import regfile_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_start,
   output logic                  clr_busy,
   regfile_access_ctrl_if.slave  a_if,
   regfile_access_ctrl_if.slave  b_if,
   output logic [AW-1:0]         rf_addr,
   output logic [DW-1:0]         rf_data,
   output logic                  rf_rst,
   output logic                  rf_write,
   input  logic [DW-1:0]         rf_out
);

   state_t        state;
   logic [AW-1:0] clr_cnt;
   logic          last_gnt;
   logic [1:0]    gnt;
   logic          arb_en;

   // A clear request in IDLE takes priority over any pending access.
   assign arb_en   = (state == IDLE) && !clr_start;
   assign clr_busy = (state == CLEAR);

   rr_arbiter2 u_arb (
      .req_a    (a_if.req),
      .req_b    (b_if.req),
      .en       (arb_en),
      .last_gnt (last_gnt),
      .gnt      (gnt)
   );

   assign a_if.gnt = gnt[PORT_A];
   assign b_if.gnt = gnt[PORT_B];

   // Register-file bus: clear strobe while sequencing, otherwise the winner.
   always_comb begin
      rf_addr  = '0;
      rf_data  = '0;
      rf_rst   = 1'b0;
      rf_write = 1'b0;
      if (state == CLEAR) begin
         rf_rst  = 1'b1;
         rf_addr = clr_cnt;
      end else if (gnt[PORT_A]) begin
         rf_addr  = a_if.addr;
         rf_write = a_if.we;
         if (a_if.we) rf_data = a_if.wdata;
      end else if (gnt[PORT_B]) begin
         rf_addr  = b_if.addr;
         rf_write = b_if.we;
         if (b_if.we) rf_data = b_if.wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= CLEAR;
         clr_cnt     <= '0;
         last_gnt    <= PORT_B;
         a_if.rvalid <= 1'b0;
         b_if.rvalid <= 1'b0;
         a_if.rdata  <= '0;
         b_if.rdata  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         a_if.rvalid <= gnt[PORT_A] && !a_if.we;
         b_if.rvalid <= gnt[PORT_B] && !b_if.we;
         if (gnt[PORT_A] && !a_if.we) a_if.rdata <= rf_out;
         if (gnt[PORT_B] && !b_if.we) b_if.rdata <= rf_out;

         case (state)
            CLEAR: begin
               if (clr_cnt == AW'(NREG - 1)) begin
                  clr_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (clr_start) begin
                  state <= CLEAR;
               end else if (gnt[PORT_A]) begin
                  last_gnt <= PORT_A;
               end else if (gnt[PORT_B]) begin
                  last_gnt <= PORT_B;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule
